// File: rtl/read_checker_pkg.sv
// Shared constants and types for the BRAM writer / read-back checker pair.
package read_checker_pkg;

    localparam int BURST_SIZE      = 4096;                      // bytes per AXI burst
    localparam int BRAM_SIZE       = 512 * 1024;                // bytes of BRAM under test
    localparam int BRAM_ADDR       = 0;                         // BRAM base address
    localparam int DEFAULT_DW      = 512;
    localparam int BEATS_PER_BURST = BURST_SIZE / (DEFAULT_DW / 8);
    localparam int TOTAL_BURSTS    = BRAM_SIZE / BURST_SIZE;    // 128
    localparam int PATTERN_W       = 16;                        // width of the counting pattern word

    typedef enum logic {
        AR_IDLE,
        AR_ISSUE
    } ar_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RUN,
        R_FINISH
    } r_state_t;

    // Beats per burst for an arbitrary data width (BEATS_PER_BURST covers the default width).
    function automatic int beats_per_burst(input int dw);
        return BURST_SIZE / (dw / 8);
    endfunction

endpackage

// File: rtl/read_checker_pattern_gen.sv
// Expected-data generator shared by the BRAM writer and the read checker:
// a 16-bit beat counter starting at 1, replicated across the bus, or all-zero.
module pattern_gen
    import read_checker_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic          zero,
    output logic [DW-1:0] data
);

    logic [PATTERN_W-1:0] count;

    // Counter restarts at 1 on clear and steps once per accepted beat; never reset per burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= PATTERN_W'(1);
        end else if (clear) begin
            count <= PATTERN_W'(1);
        end else if (advance) begin
            count <= count + PATTERN_W'(1);
        end
    end

    assign data = zero ? '0 : {(DW / PATTERN_W){count}};

endmodule

// File: rtl/read_checker.sv
// Read-back checker: reads the whole BRAM in 4 KiB INCR bursts and compares
// every beat against the writer's pattern (or all-zero).
//
// state     | meaning
// AR_IDLE   | no read addresses to issue
// AR_ISSUE  | presenting burst addresses until all 128 are accepted
// R_IDLE    | waiting for start
// R_RUN     | accepting and checking read beats
// R_FINISH  | one cycle: pulse done, register pass
module read_checker
    import read_checker_pkg::*;
#(
    parameter int DW = 512,
    parameter int AW = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            expect_zero,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [31:0]     err_count,
    output logic [AW-1:0]   first_err_addr,
    output logic            resp_err,
    output logic            rlast_err,
    // read address channel
    output logic [3:0]      M_AXI_ARID,
    output logic [AW-1:0]   M_AXI_ARADDR,
    output logic [7:0]      M_AXI_ARLEN,
    output logic [2:0]      M_AXI_ARSIZE,
    output logic [1:0]      M_AXI_ARBURST,
    output logic            M_AXI_ARLOCK,
    output logic [3:0]      M_AXI_ARCACHE,
    output logic [2:0]      M_AXI_ARPROT,
    output logic [3:0]      M_AXI_ARQOS,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    // read data channel
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RLAST,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY,
    // write channels (unused by the checker)
    output logic [3:0]      M_AXI_AWID,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [2:0]      M_AXI_AWPROT,
    output logic [3:0]      M_AXI_AWQOS,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [3:0]      M_AXI_BID,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);

    localparam int BPB         = beats_per_burst(DW);
    localparam int TOTAL_BEATS = TOTAL_BURSTS * BPB;
    localparam int BEAT_W      = $clog2(TOTAL_BEATS);
    localparam int BIB_W       = $clog2(BPB);
    localparam int BYTE_SHIFT  = $clog2(DW / 8);
    localparam int BCNT_W      = $clog2(TOTAL_BURSTS + 1);

    ar_state_t         ar_state, ar_next;
    r_state_t          r_state, r_next;
    logic [AW-1:0]     araddr;
    logic [BCNT_W-1:0] ar_count;
    logic [BEAT_W-1:0] rbeat_idx;
    logic              exp_zero_q;
    logic [DW-1:0]     expected;
    logic              busy_int, start_ok, ar_hs, r_hs;
    logic              last_in_burst, final_beat, data_mismatch;
    logic              unused_write_inputs;

    assign busy_int      = (ar_state != AR_IDLE) || (r_state != R_IDLE);
    assign start_ok      = start && !busy_int;
    assign M_AXI_ARVALID = (ar_state == AR_ISSUE) && !reset;
    assign M_AXI_RREADY  = (r_state == R_RUN) && !reset;
    assign ar_hs         = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs          = M_AXI_RVALID && M_AXI_RREADY;
    assign last_in_burst = &rbeat_idx[BIB_W-1:0];
    assign final_beat    = (rbeat_idx == BEAT_W'(TOTAL_BEATS - 1));
    assign data_mismatch = (M_AXI_RDATA != expected);
    assign busy          = busy_int && !reset;

    pattern_gen #(.DW(DW)) u_pattern (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_ok),
        .advance (r_hs),
        .zero    (exp_zero_q),
        .data    (expected)
    );

    // AR next state: issue bursts back to back; only slave backpressure throttles.
    always_comb begin
        ar_next = ar_state;
        case (ar_state)
            AR_IDLE:  if (start_ok) ar_next = AR_ISSUE;
            AR_ISSUE: if (ar_hs && (ar_count == BCNT_W'(TOTAL_BURSTS))) ar_next = AR_IDLE;
            default:  ar_next = AR_IDLE;
        endcase
    end

    // AR state, address and burst count; address only moves on a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            araddr   <= '0;
            ar_count <= '0;
        end else begin
            ar_state <= ar_next;
            if (start_ok) begin
                araddr   <= AW'(BRAM_ADDR);
                ar_count <= BCNT_W'(1);
            end else if (ar_hs) begin
                araddr   <= araddr + AW'(BURST_SIZE);
                ar_count <= ar_count + BCNT_W'(1);
            end
        end
    end

    // R next state and done pulse.
    always_comb begin
        r_next = r_state;
        done   = 1'b0;
        case (r_state)
            R_IDLE:   if (start_ok) r_next = R_RUN;
            R_RUN:    if (r_hs && final_beat) r_next = R_FINISH;
            R_FINISH: begin
                r_next = R_IDLE;
                done   = !reset;
            end
            default:  r_next = R_IDLE;
        endcase
    end

    // R state, per-beat checks and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= R_IDLE;
            rbeat_idx      <= '0;
            exp_zero_q     <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            resp_err       <= 1'b0;
            rlast_err      <= 1'b0;
            pass           <= 1'b0;
        end else begin
            r_state <= r_next;
            if (start_ok) begin
                rbeat_idx      <= '0;
                exp_zero_q     <= expect_zero;
                err_count      <= '0;
                first_err_addr <= '0;
                resp_err       <= 1'b0;
                rlast_err      <= 1'b0;
                pass           <= 1'b0;
            end else if (r_hs) begin
                rbeat_idx <= rbeat_idx + BEAT_W'(1);
                if (data_mismatch) begin
                    if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
                    // err_count is still zero only for the first mismatch of this check
                    if (err_count == 32'd0) first_err_addr <= AW'(rbeat_idx) << BYTE_SHIFT;
                end
                if (M_AXI_RRESP != 2'b00) resp_err <= 1'b1;
                if (M_AXI_RLAST != last_in_burst) rlast_err <= 1'b1;
            end
            // In FINISH the error registers already include the final beat.
            if (r_state == R_FINISH) pass <= (err_count == 32'd0) && !resp_err && !rlast_err;
        end
    end

    assign M_AXI_ARADDR  = araddr;
    assign M_AXI_ARLEN   = 8'(BPB - 1);
    assign M_AXI_ARSIZE  = 3'(BYTE_SHIFT);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARPROT  = 3'b010;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = '0;
    assign M_AXI_AWLEN   = '0;
    assign M_AXI_AWSIZE  = '0;
    assign M_AXI_AWBURST = '0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WDATA   = '0;
    assign M_AXI_WSTRB   = '0;
    assign M_AXI_WLAST   = 1'b0;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b0;

    assign unused_write_inputs = &{1'b0, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID,
                                   M_AXI_BRESP, M_AXI_BVALID};

endmodule
